// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : FETCH/DECODE/EXEC/MEM/WB sequencer and select/enable driver for
//            the multi-cycle MIPS datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
    parameter int W_OP = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [W_OP-1:0] opcode,
    input  logic [W_OP-1:0] funct,
    input  logic            zero,
    output logic            ir_we,
    output logic            pc_we,
    output logic [1:0]      pc_sel,
    output logic            reg_we,
    output logic [1:0]      reg_dst,
    output logic [1:0]      mem_to_reg,
    output logic            alu_src,
    output logic [1:0]      ext_op,
    output logic [1:0]      alu_op,
    output logic            mem_we,
    output logic            illegal,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        CL_NOP  = 4'd0,
        CL_ADDU = 4'd1,
        CL_SUBU = 4'd2,
        CL_JR   = 4'd3,
        CL_ORI  = 4'd4,
        CL_LUI  = 4'd5,
        CL_LW   = 4'd6,
        CL_SW   = 4'd7,
        CL_BEQ  = 4'd8,
        CL_J    = 4'd9,
        CL_JAL  = 4'd10,
        CL_ILL  = 4'd11
    } class_t;

    state_t r_state;
    state_t w_next;
    class_t r_class;
    class_t w_class;

    // Live decode of the IR fields; only consumed during DECODE.
    always_comb begin
        w_class = CL_ILL;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100001: w_class = CL_ADDU;
                    6'b100011: w_class = CL_SUBU;
                    6'b001000: w_class = CL_JR;
                    6'b000000: w_class = CL_NOP;
                    default:   w_class = CL_ILL;
                endcase
            end
            6'b001101: w_class = CL_ORI;
            6'b001111: w_class = CL_LUI;
            6'b100011: w_class = CL_LW;
            6'b101011: w_class = CL_SW;
            6'b000100: w_class = CL_BEQ;
            6'b000010: w_class = CL_J;
            6'b000011: w_class = CL_JAL;
            default:   w_class = CL_ILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_FETCH;
            r_class <= CL_NOP;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_class <= w_class;
            end
        end
    end

    always_comb begin
        w_next     = ST_FETCH;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 2'b00;
        reg_we     = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src    = 1'b0;
        ext_op     = 2'b00;
        alu_op     = 2'b00;
        mem_we     = 1'b0;
        illegal    = 1'b0;

        case (r_state)
            ST_FETCH: begin
                ir_we  = 1'b1;
                pc_we  = 1'b1;
                w_next = ST_DECODE;
            end
            ST_DECODE: begin
                case (w_class)
                    CL_J: begin
                        pc_we  = 1'b1;
                        pc_sel = 2'b10;
                    end
                    CL_JAL: begin
                        pc_we      = 1'b1;
                        pc_sel     = 2'b10;
                        reg_we     = 1'b1;
                        reg_dst    = 2'b10;
                        mem_to_reg = 2'b10;
                    end
                    CL_JR: begin
                        pc_we  = 1'b1;
                        pc_sel = 2'b11;
                    end
                    CL_NOP: ;
                    CL_ILL: illegal = 1'b1;
                    default: w_next = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (r_class)
                    CL_ADDU: w_next = ST_WB;
                    CL_SUBU: begin
                        alu_op = 2'b01;
                        w_next = ST_WB;
                    end
                    CL_ORI: begin
                        alu_src = 1'b1;
                        alu_op  = 2'b10;
                        w_next  = ST_WB;
                    end
                    CL_LUI: begin
                        alu_src = 1'b1;
                        ext_op  = 2'b10;
                        w_next  = ST_WB;
                    end
                    CL_LW, CL_SW: begin
                        alu_src = 1'b1;
                        ext_op  = 2'b01;
                        w_next  = ST_MEM;
                    end
                    CL_BEQ: begin
                        alu_op = 2'b01;
                        ext_op = 2'b01;
                        if (zero) begin
                            pc_we  = 1'b1;
                            pc_sel = 2'b01;
                        end
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                alu_src = 1'b1;
                ext_op  = 2'b01;
                if (r_class == CL_SW) begin
                    mem_we = 1'b1;
                end else if (r_class == CL_LW) begin
                    w_next = ST_WB;
                end
            end
            ST_WB: begin
                reg_we = 1'b1;
                case (r_class)
                    CL_ADDU, CL_SUBU: reg_dst = 2'b01;
                    // Immediate ALU controls stay up so the result path is stable.
                    CL_ORI: begin
                        alu_src = 1'b1;
                        alu_op  = 2'b10;
                    end
                    CL_LUI: begin
                        alu_src = 1'b1;
                        ext_op  = 2'b10;
                    end
                    CL_LW: mem_to_reg = 2'b01;
                    default: ;
                endcase
            end
            default: w_next = ST_FETCH;
        endcase

        // Reset silences every output so an abandoned instruction writes nothing.
        if (!reset) begin
            ir_we      = 1'b0;
            pc_we      = 1'b0;
            pc_sel     = 2'b00;
            reg_we     = 1'b0;
            reg_dst    = 2'b00;
            mem_to_reg = 2'b00;
            alu_src    = 1'b0;
            ext_op     = 2'b00;
            alu_op     = 2'b00;
            mem_we     = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign state = r_state;

endmodule

`default_nettype wire
